// File: rtl/qbus_ram_slave_pkg.sv
// Shared definitions for the Q-bus RAM slave.
//   state_t          3-bit FSM state encoding
//   QB_ASSERTED      electrical level of an asserted Q-bus strobe
//   qb_active()      converts a pin level to an "asserted" flag
//   DEF_RPLY_DELAY   default strobe-to-reply delay in clocks
package qbus_ram_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_RPLY = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_RPLY = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

  localparam logic QB_ASSERTED    = 1'b0;
  localparam int   DEF_RPLY_DELAY = 2;
  localparam int   QB_LANES       = 2;
  localparam int   QB_LANE_W      = 8;

  function automatic logic qb_active(input logic pin_n);
    return pin_n == QB_ASSERTED;
  endfunction

endpackage

// File: rtl/qbus_ram_slave_if.sv
// Q-bus pin bundle as seen by the RAM slave.
//   init_n, sync_n, din_n, dout_n, wtbt_n : master-driven control, active low
//   ad_in_n                               : inverted AD bus from the pins
//   ad_out_n, ad_oe                       : slave read data / pin output enable
//   rply_n                                : slave reply, active low
//   sel                                   : debug, slave owns the current cycle
interface qbus_ram_slave_if;
  logic        init_n;
  logic        sync_n;
  logic        din_n;
  logic        dout_n;
  logic        wtbt_n;
  logic [15:0] ad_in_n;
  logic [15:0] ad_out_n;
  logic        ad_oe;
  logic        rply_n;
  logic        sel;

  modport slave (
    input  init_n, sync_n, din_n, dout_n, wtbt_n, ad_in_n,
    output ad_out_n, ad_oe, rply_n, sel
  );

  modport master (
    output init_n, sync_n, din_n, dout_n, wtbt_n, ad_in_n,
    input  ad_out_n, ad_oe, rply_n, sel
  );
endinterface

// File: rtl/qbus_ram_array.sv
// 2^ADDR_BITS x (NUM_LANES*VEC_W) synchronous RAM, one array per byte lane.
//   clk    : clock
//   addr   : word address (shared by read and write)
//   we     : per-lane write enable
//   wdata  : write data, lane-packed
//   re     : read enable; rdata updates one clock later, otherwise holds
//   rdata  : registered read data, lane-packed
// No reset on the storage or read register so the arrays map onto block RAM.
module qbus_ram_array #(
  parameter int ADDR_BITS = 12,
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 8
) (
  input  logic                                clk,
  input  logic [ADDR_BITS-1:0]                addr,
  input  logic [NUM_LANES-1:0]                we,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     wdata,
  input  logic                                re,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] mem [2**ADDR_BITS];
    logic [VEC_W-1:0] rd;

    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[l];
      if (re)    rd        <= mem[addr];
    end

    assign rdata[l] = rd;
  end

endmodule

// File: rtl/qbus_ram_slave.sv
// Q-bus memory slave: decodes SYNC address cycles and serves DATI, DATO(B)
// and DATIO(B) from an on-chip byte-writable RAM.
//   clk    : system clock, bus pins sampled on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : Q-bus pins (slave modport), see qbus_ram_slave_if
// Every bus input passes through one register stage; the FSM acts on the
// registered copies. INIT is used raw as a synchronous abort.
module qbus_ram_slave
  import qbus_ram_slave_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'o000000,
  parameter int          ADDR_BITS  = 12,
  parameter int          RPLY_DELAY = DEF_RPLY_DELAY
) (
  input  logic             clk,
  input  logic             rst_n,
  qbus_ram_slave_if.slave  bus
);

  localparam int         HI       = ADDR_BITS + 1;
  localparam logic [3:0] CNT_LAST = 4'(RPLY_DELAY - 1);

  // registered pins, converted to asserted-high / true-data form
  logic        sync_q, sync_qq, din_q, dout_q, wtbt_q;
  logic [15:0] ad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
      wtbt_q  <= 1'b0;
      ad_q    <= '0;
    end else begin
      sync_q  <= qb_active(bus.sync_n);
      sync_qq <= sync_q;
      din_q   <= qb_active(bus.din_n);
      dout_q  <= qb_active(bus.dout_n);
      wtbt_q  <= qb_active(bus.wtbt_n);
      ad_q    <= ~bus.ad_in_n;
    end
  end

  state_t               state;
  logic [3:0]           cnt;
  logic [ADDR_BITS:0]   addr_r;   // bit 0 is the byte lane
  logic                 rply_n_r, ad_oe_r, sel_r;
  logic [15:0]          ad_out_n_r;

  // RAM access strobes, valid only on the ADDR -> data-phase edge
  logic                         data_ok, rd_go, wr_go;
  logic [QB_LANES-1:0]          we;
  logic [QB_LANES-1:0][QB_LANE_W-1:0] wdata, rdata;

  assign data_ok = (state == ST_ADDR) && bus.init_n && sync_q;
  assign rd_go   = data_ok && din_q && !dout_q;
  assign wr_go   = data_ok && dout_q && !din_q;
  assign wdata   = ad_q;

  // WTBT asserted in the data phase selects a single byte lane
  always_comb begin
    we = '0;
    if (wr_go) we = wtbt_q ? (addr_r[0] ? 2'b10 : 2'b01) : 2'b11;
  end

  qbus_ram_array #(
    .ADDR_BITS (ADDR_BITS),
    .NUM_LANES (QB_LANES),
    .VEC_W     (QB_LANE_W)
  ) u_ram (
    .clk   (clk),
    .addr  (addr_r[ADDR_BITS:1]),
    .we    (we),
    .wdata (wdata),
    .re    (rd_go),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_r     <= '0;
      rply_n_r   <= 1'b1;
      ad_oe_r    <= 1'b0;
      ad_out_n_r <= 16'hFFFF;
      sel_r      <= 1'b0;
    end else if (!bus.init_n || (state != ST_IDLE && !sync_q)) begin
      // INIT or SYNC negation abandons the cycle; committed writes stay
      state      <= ST_IDLE;
      cnt        <= '0;
      rply_n_r   <= 1'b1;
      ad_oe_r    <= 1'b0;
      ad_out_n_r <= 16'hFFFF;
      sel_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // only a fresh SYNC falling edge opens a cycle, so a SYNC still
          // held low across an INIT does not replay a stale address
          if (sync_q && !sync_qq) begin
            addr_r <= ad_q[ADDR_BITS:0];
            if (ad_q[15:HI] == BASE_ADDR[15:HI]) begin
              state <= ST_ADDR;
              sel_r <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          cnt <= '0;
          if (din_q && dout_q) begin
            state <= ST_IGNORE;
            sel_r <= 1'b0;
          end else if (din_q) begin
            state <= ST_RD_WAIT;
          end else if (dout_q) begin
            state <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cnt == CNT_LAST) begin
            ad_out_n_r <= ~rdata;
            ad_oe_r    <= 1'b1;
            rply_n_r   <= 1'b0;
            state      <= ST_RD_RPLY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RD_RPLY: begin
          if (!din_q) begin
            ad_out_n_r <= 16'hFFFF;
            ad_oe_r    <= 1'b0;
            rply_n_r   <= 1'b1;
            state      <= ST_ADDR;
          end
        end
        ST_WR_WAIT: begin
          if (cnt == CNT_LAST) begin
            rply_n_r <= 1'b0;
            state    <= ST_WR_RPLY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_WR_RPLY: begin
          if (!dout_q) begin
            rply_n_r <= 1'b1;
            state    <= ST_ADDR;
          end
        end
        ST_IGNORE: ;
        default: begin
          state <= ST_IDLE;
          sel_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rply_n   = rply_n_r;
  assign bus.ad_oe    = ad_oe_r;
  assign bus.ad_out_n = ad_out_n_r;
  assign bus.sel      = sel_r;

endmodule

// File: tb/tb_qbus_ram_slave.sv
// Directed bench for qbus_ram_slave: master tasks drive bus cycles and push
// the expected reply into a queue; a monitor pops on every RPLY assertion.
module tb_qbus_ram_slave;

  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qbus_ram_slave_if bus ();

  qbus_ram_slave #(
    .BASE_ADDR  (16'o000000),
    .ADDR_BITS  (12),
    .RPLY_DELAY (RD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_rply = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] v;
    if (prev_rply === 1'b1 && bus.rply_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rply: got reply with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rply_oe", {31'd0, bus.ad_oe}, {31'd0, e.is_rd});
        if (e.is_rd) begin
          v = ~bus.ad_out_n;
          chk("rd_data", {16'd0, v}, {16'd0, e.data});
        end
      end
    end
    prev_rply = bus.rply_n;
  end

  task automatic wait_rply(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.rply_n !== lvl && n < 30);
  endtask

  task automatic start(input logic [15:0] a, input bit wr);
    @(negedge clk);
    bus.ad_in_n = ~a;
    bus.wtbt_n  = ~wr;
    bus.sync_n  = 1'b0;
    @(negedge clk);
    bus.ad_in_n = 16'hFFFF;
    bus.wtbt_n  = 1'b1;
  endtask

  task automatic end_cyc();
    @(negedge clk);
    bus.sync_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic rd(input logic [15:0] d, input bit lat);
    int n;
    @(negedge clk);
    bus.din_n = 1'b0;
    exp_q.push_back('{1'b1, d});
    wait_rply(1'b0, n);
    if (lat) chk("rd_latency", n, RD + 2);
    @(negedge clk);
    bus.din_n = 1'b1;
    wait_rply(1'b1, n);
    if (lat) chk("rd_release", n, 2);
  endtask

  task automatic wr(input logic [15:0] d, input bit bytew);
    int n;
    @(negedge clk);
    bus.dout_n  = 1'b0;
    bus.ad_in_n = ~d;
    bus.wtbt_n  = ~bytew;
    exp_q.push_back('{1'b0, 16'h0});
    wait_rply(1'b0, n);
    @(negedge clk);
    bus.dout_n  = 1'b1;
    bus.ad_in_n = 16'hFFFF;
    bus.wtbt_n  = 1'b1;
    wait_rply(1'b1, n);
    chk("wr_release", {31'd0, bus.rply_n}, 32'd1);
  endtask

  task automatic dato(input logic [15:0] a, input logic [15:0] d, input bit bytew);
    start(a, 1'b1);
    wr(d, bytew);
    end_cyc();
  endtask

  task automatic dati(input logic [15:0] a, input logic [15:0] d, input bit lat);
    start(a, 1'b0);
    rd(d, lat);
    end_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    bus.init_n  = 1'b1;
    bus.sync_n  = 1'b1;
    bus.din_n   = 1'b1;
    bus.dout_n  = 1'b1;
    bus.wtbt_n  = 1'b1;
    bus.ad_in_n = 16'hFFFF;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rply", {31'd0, bus.rply_n}, 32'd1);
    chk("rst_oe",   {31'd0, bus.ad_oe},  32'd0);
    chk("rst_out",  {16'd0, bus.ad_out_n}, 32'h0000FFFF);
    chk("rst_sel",  {31'd0, bus.sel},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // word write / read with latency checks
    dato(16'o001000, 16'o012345, 1'b0);
    dati(16'o001000, 16'o012345, 1'b1);

    // high byte write keeps low byte
    dato(16'o001000, 16'o000000, 1'b0);
    dato(16'o001001, 16'hFFFF, 1'b1);
    dati(16'o001000, 16'o177400, 1'b0);

    // low byte write keeps high byte
    dato(16'o001000, 16'hAAAA, 1'b1);
    dati(16'o001000, 16'hFFAA, 1'b0);

    // last word of the window
    dato(16'o017776, 16'hBEEF, 1'b0);
    dati(16'o017776, 16'hBEEF, 1'b1);
    dati(16'o001000, 16'hFFAA, 1'b0);

    // out-of-window address: no reply, no drive, not selected
    start(16'o020000, 1'b0);
    @(negedge clk);
    bus.din_n = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rply_n !== 1'b1 || bus.ad_oe !== 1'b0 || bus.sel !== 1'b0) ok = 1'b0;
    end
    chk("miss_quiet", {31'd0, ok}, 32'd1);
    @(negedge clk);
    bus.din_n = 1'b1;
    end_cyc();

    // DATIO: read then write under one SYNC
    dato(16'o000100, 16'd5, 1'b0);
    start(16'o000100, 1'b1);
    @(posedge clk); #1;
    chk("hit_sel", {31'd0, bus.sel}, 32'd1);
    rd(16'd5, 1'b1);
    wr(16'd6, 1'b0);
    end_cyc();
    dati(16'o000100, 16'd6, 1'b0);

    // SYNC negated during RD_WAIT
    start(16'o001000, 1'b0);
    @(negedge clk);
    bus.din_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.sync_n = 1'b1;
    bus.din_n  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_sel", {31'd0, bus.sel}, 32'd0);
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rply_n !== 1'b1) ok = 1'b0;
    end
    chk("abort_norply", {31'd0, ok}, 32'd1);

    // INIT in WR_RPLY; the write itself is already committed
    start(16'o001000, 1'b1);
    @(negedge clk);
    bus.dout_n  = 1'b0;
    bus.ad_in_n = ~16'h1234;
    exp_q.push_back('{1'b0, 16'h0});
    wait_rply(1'b0, n);
    @(negedge clk);
    bus.init_n = 1'b0;
    @(posedge clk); #1;
    chk("init_rply", {31'd0, bus.rply_n}, 32'd1);
    chk("init_sel",  {31'd0, bus.sel},    32'd0);
    @(negedge clk);
    bus.init_n  = 1'b1;
    bus.sync_n  = 1'b1;
    bus.dout_n  = 1'b1;
    bus.ad_in_n = 16'hFFFF;
    repeat (3) @(posedge clk);
    dati(16'o001000, 16'h1234, 1'b0);

    // async reset while RPLY is asserted; RAM contents survive
    start(16'o001000, 1'b0);
    @(negedge clk);
    bus.din_n = 1'b0;
    exp_q.push_back('{1'b1, 16'h1234});
    wait_rply(1'b0, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rply", {31'd0, bus.rply_n}, 32'd1);
    chk("arst_oe",   {31'd0, bus.ad_oe},  32'd0);
    chk("arst_out",  {16'd0, bus.ad_out_n}, 32'h0000FFFF);
    @(negedge clk);
    bus.din_n  = 1'b1;
    bus.sync_n = 1'b1;
    rst_n      = 1'b1;
    repeat (3) @(posedge clk);
    dati(16'o001000, 16'h1234, 1'b1);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
